pipeline_if: RTL and testbench

//  Instruction-fetch stage. Owns the PC and fetches 32-bit words through a req/ack

---
 rtl/pipeline_if.sv | 214 +++++++++++++++++++++
 tb/tb_pipeline_if.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_if.sv
// pipeline_if: instruction-fetch stage with req/ack memory port and IF/ID register.
// Optional direct-mapped I-cache enabled by defining IF_ICACHE_EN.
module pipeline_if #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ICACHE_LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [4:0]  stall_i,
    input  logic [4:0]  flush_i,
    input  logic        br_e_i,
    input  logic [31:0] br_addr_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    typedef enum logic {
        S_IDLE,
        S_FETCH
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic        r_req;
    logic [31:0] r_addr;
    logic        r_discard;
    logic [31:0] r_inst;
    logic [31:0] r_pc_o;
    logic        r_hold_v;
    logic [31:0] r_hold_inst;
    logic [31:0] r_hold_pc;

    logic [31:0] w_pc_nxt;
    logic        w_req_nxt;
    logic [31:0] w_addr_nxt;
    logic        w_discard_nxt;
    logic [31:0] w_inst_nxt;
    logic [31:0] w_pc_o_nxt;
    logic        w_hold_v_nxt;
    logic [31:0] w_hold_inst_nxt;
    logic [31:0] w_hold_pc_nxt;

    logic        w_kill;
    logic        w_redirect;
    logic        w_go;
    logic        w_mem_ok;
    logic        w_hit;
    logic        w_hit_ok;
    logic        w_word_ok;
    logic [31:0] w_word;
    logic [31:0] w_word_pc;
    logic [31:0] w_cdata;
    logic        w_unused;

    // A flush kills the in-flight fetch even when the PC itself is stalled.
    assign w_kill     = br_e_i | flush_i[1];
    assign w_redirect = br_e_i | (flush_i[1] & ~stall_i[0]);
    assign w_go       = (r_state == S_IDLE) & ~stall_i[0]
                      & ~r_hold_v & ~w_kill;
    assign w_mem_ok   = (r_state == S_FETCH) & mem_ack_i
                      & ~r_discard & ~w_kill;
    assign w_hit_ok   = w_go & w_hit;
    assign w_word_ok  = w_mem_ok | w_hit_ok;
    assign w_word     = w_hit_ok ? w_cdata : mem_data_i;
    assign w_word_pc  = w_hit_ok ? r_pc : r_addr;

`ifdef IF_ICACHE_EN
    localparam int IW = $clog2(ICACHE_LINES);
    localparam int TW = 32 - IW - 2;

    logic [ICACHE_LINES-1:0] r_cvalid;
    logic [31:0]             r_cdata [ICACHE_LINES];
    logic [TW-1:0]           r_ctag  [ICACHE_LINES];
    logic [IW-1:0]           w_ridx;
    logic [IW-1:0]           w_widx;

    assign w_ridx  = r_pc[IW+1:2];
    assign w_widx  = r_addr[IW+1:2];
    assign w_cdata = r_cdata[w_ridx];
    assign w_hit   = r_cvalid[w_ridx]
                   & (r_ctag[w_ridx] == r_pc[31:IW+2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cvalid <= '0;
        end else if (rdy && w_mem_ok) begin
            r_cvalid[w_widx] <= 1'b1;
        end
    end

    // Data and tag arrays need no reset; the valid bits gate them.
    always_ff @(posedge clk) begin
        if (rdy && w_mem_ok) begin
            r_cdata[w_widx] <= mem_data_i;
            r_ctag[w_widx]  <= r_addr[31:IW+2];
        end
    end

    assign w_unused = ^{stall_i[4:2], flush_i[4:2], flush_i[0]};
`else
    logic [31:0] w_unused_lines;

    assign w_hit          = 1'b0;
    assign w_cdata        = 32'h0;
    assign w_unused_lines = ICACHE_LINES;
    assign w_unused       = ^{stall_i[4:2], flush_i[4:2], flush_i[0],
                              w_unused_lines};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_req       <= 1'b0;
            r_addr      <= 32'h0;
            r_discard   <= 1'b0;
            r_inst      <= 32'h0;
            r_pc_o      <= 32'h0;
            r_hold_v    <= 1'b0;
            r_hold_inst <= 32'h0;
            r_hold_pc   <= 32'h0;
        end else if (rdy) begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_req       <= w_req_nxt;
            r_addr      <= w_addr_nxt;
            r_discard   <= w_discard_nxt;
            r_inst      <= w_inst_nxt;
            r_pc_o      <= w_pc_o_nxt;
            r_hold_v    <= w_hold_v_nxt;
            r_hold_inst <= w_hold_inst_nxt;
            r_hold_pc   <= w_hold_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_req_nxt     = r_req;
        w_addr_nxt    = r_addr;
        w_discard_nxt = r_discard;
        unique case (r_state)
            S_IDLE: begin
                if (w_go && !w_hit) begin
                    w_state_nxt = S_FETCH;
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = r_pc;
                end
            end
            S_FETCH: begin
                if (mem_ack_i) begin
                    w_state_nxt   = S_IDLE;
                    w_req_nxt     = 1'b0;
                    w_discard_nxt = 1'b0;
                end else if (w_kill) begin
                    w_discard_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_pc_nxt = r_pc;
        if (w_redirect) begin
            w_pc_nxt = br_addr_i;
        end else if (w_word_ok) begin
            w_pc_nxt = r_pc + 32'd4;
        end
    end

    // IF/ID register and its single-entry overflow buffer.
    always_comb begin
        w_inst_nxt      = r_inst;
        w_pc_o_nxt      = r_pc_o;
        w_hold_v_nxt    = r_hold_v;
        w_hold_inst_nxt = r_hold_inst;
        w_hold_pc_nxt   = r_hold_pc;
        if (flush_i[1]) begin
            w_inst_nxt   = 32'h0;
            w_hold_v_nxt = 1'b0;
        end else if (stall_i[1]) begin
            if (w_word_ok) begin
                w_hold_v_nxt    = 1'b1;
                w_hold_inst_nxt = w_word;
                w_hold_pc_nxt   = w_word_pc;
            end
        end else if (r_hold_v) begin
            w_inst_nxt   = r_hold_inst;
            w_pc_o_nxt   = r_hold_pc;
            w_hold_v_nxt = 1'b0;
        end else if (w_word_ok) begin
            w_inst_nxt = w_word;
            w_pc_o_nxt = w_word_pc;
        end else begin
            w_inst_nxt = 32'h0;
        end
    end

    assign mem_req_o  = r_req;
    assign mem_addr_o = r_addr;
    assign inst_o     = r_inst;
    assign pc_o       = r_pc_o;

endmodule

// File: tb/tb_pipeline_if.sv
// tb_pipeline_if: directed cycle-exact checks of the fetch stage.
// Memory responder acks two cycles after a request appears.
module tb_pipeline_if;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic [4:0]  stall_i = 5'b0;
    logic [4:0]  flush_i = 5'b0;
    logic        br_e_i = 1'b0;
    logic [31:0] br_addr_i = 32'h0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_data_i = 32'h0;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    int tests = 0;
    int fails = 0;
    int mcnt  = 0;

    pipeline_if dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .br_e_i     (br_e_i),
        .br_addr_i  (br_addr_i),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .mem_data_i (mem_data_i),
        .inst_o     (inst_o),
        .pc_o       (pc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mw(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    always @(negedge clk) begin
        if (rst || !mem_req_o || mem_ack_i) begin
            mem_ack_i = 1'b0;
            mcnt      = 0;
        end else if (rdy) begin
            mcnt = mcnt + 1;
            if (mcnt == 2) begin
                mem_ack_i  = 1'b1;
                mem_data_i = mw(mem_addr_o);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if ({mem_req_o, mem_addr_o, inst_o, pc_o} !== 97'h0) begin
            fails++;
            $display("FAIL reset_state: req=%0b addr=%h inst=%h pc=%h want all 0",
                     mem_req_o, mem_addr_o, inst_o, pc_o);
        end
        rst = 1'b0;
        tick();
        tests++;
        if ({mem_req_o, mem_addr_o, inst_o} !== {1'b1, 32'h0, 32'h0}) begin
            fails++;
            $display("FAIL first_req: req=%0b addr=%h inst=%h want 1/0/0",
                     mem_req_o, mem_addr_o, inst_o);
        end
    endtask

    task automatic test_sequential();
        tick();
        tests++;
        if ({mem_req_o, mem_addr_o, inst_o} !== {1'b1, 32'h0, 32'h0}) begin
            fails++;
            $display("FAIL req_stable: req=%0b addr=%h inst=%h want 1/0/0",
                     mem_req_o, mem_addr_o, inst_o);
        end
        tick();
        tests++;
        if ({inst_o, pc_o, mem_req_o} !== {mw(32'h0), 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL word0: inst=%h pc=%h req=%0b want %h/0/0",
                     inst_o, pc_o, mem_req_o, mw(32'h0));
        end
        tick();
        tests++;
        if ({mem_req_o, mem_addr_o, inst_o} !== {1'b1, 32'h4, 32'h0}) begin
            fails++;
            $display("FAIL req4_bubble: req=%0b addr=%h inst=%h want 1/4/0",
                     mem_req_o, mem_addr_o, inst_o);
        end
        tick();
        tick();
        tests++;
        if ({inst_o, pc_o} !== {mw(32'h4), 32'h4}) begin
            fails++;
            $display("FAIL word4: inst=%h pc=%h want %h/4",
                     inst_o, pc_o, mw(32'h4));
        end
        tick();
        tests++;
        if ({mem_req_o, mem_addr_o, inst_o} !== {1'b1, 32'h8, 32'h0}) begin
            fails++;
            $display("FAIL req8: req=%0b addr=%h inst=%h want 1/8/0",
                     mem_req_o, mem_addr_o, inst_o);
        end
    endtask

    task automatic test_branch();
        br_e_i    = 1'b1;
        br_addr_i = 32'h100;
        tick();
        br_e_i = 1'b0;
        tests++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h8}) begin
            fails++;
            $display("FAIL br_req_held: req=%0b addr=%h want 1/8",
                     mem_req_o, mem_addr_o);
        end
        tick();
        tests++;
        if ({inst_o, pc_o, mem_req_o} !== {32'h0, 32'h4, 1'b0}) begin
            fails++;
            $display("FAIL br_drop: inst=%h pc=%h req=%0b want 0/4/0",
                     inst_o, pc_o, mem_req_o);
        end
        tick();
        tests++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h100}) begin
            fails++;
            $display("FAIL br_target_req: req=%0b addr=%h want 1/100",
                     mem_req_o, mem_addr_o);
        end
        tick();
        tick();
        tests++;
        if ({inst_o, pc_o} !== {mw(32'h100), 32'h100}) begin
            fails++;
            $display("FAIL br_target_word: inst=%h pc=%h want %h/100",
                     inst_o, pc_o, mw(32'h100));
        end
    endtask

    task automatic test_stall_hold();
        br_e_i    = 1'b1;
        br_addr_i = 32'hC;
        tick();
        br_e_i = 1'b0;
        tests++;
        if ({inst_o, pc_o, mem_req_o} !== {32'h0, 32'h100, 1'b0}) begin
            fails++;
            $display("FAIL idle_redirect: inst=%h pc=%h req=%0b want 0/100/0",
                     inst_o, pc_o, mem_req_o);
        end
        tick();
        tests++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'hC}) begin
            fails++;
            $display("FAIL reqC: req=%0b addr=%h want 1/c",
                     mem_req_o, mem_addr_o);
        end
        stall_i = 5'b00010;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({inst_o, pc_o} !== {32'h0, 32'h100}) begin
                fails++;
                $display("FAIL stall_frozen%0d: inst=%h pc=%h want 0/100",
                         i, inst_o, pc_o);
            end
        end
        tests++;
        if (mem_req_o !== 1'b0) begin
            fails++;
            $display("FAIL hold_blocks_req: req=%0b want 0", mem_req_o);
        end
        stall_i = 5'b0;
        tick();
        tests++;
        if ({inst_o, pc_o, mem_req_o} !== {mw(32'hC), 32'hC, 1'b0}) begin
            fails++;
            $display("FAIL hold_release: inst=%h pc=%h req=%0b want %h/c/0",
                     inst_o, pc_o, mem_req_o, mw(32'hC));
        end
        tick();
        tests++;
        if ({inst_o, mem_req_o, mem_addr_o} !== {32'h0, 1'b1, 32'h10}) begin
            fails++;
            $display("FAIL no_dup: inst=%h req=%0b addr=%h want 0/1/10",
                     inst_o, mem_req_o, mem_addr_o);
        end
        tick();
        tick();
        tests++;
        if ({inst_o, pc_o} !== {mw(32'h10), 32'h10}) begin
            fails++;
            $display("FAIL word10: inst=%h pc=%h want %h/10",
                     inst_o, pc_o, mw(32'h10));
        end
    endtask

    task automatic test_flush();
        tick();
        tests++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h14}) begin
            fails++;
            $display("FAIL req14: req=%0b addr=%h want 1/14",
                     mem_req_o, mem_addr_o);
        end
        tick();
        flush_i   = 5'b00010;
        br_addr_i = 32'h200;
        tick();
        flush_i = 5'b0;
        tests++;
        if ({inst_o, mem_req_o} !== {32'h0, 1'b0}) begin
            fails++;
            $display("FAIL flush_ack: inst=%h req=%0b want 0/0",
                     inst_o, mem_req_o);
        end
        tick();
        tests++;
        if ({mem_req_o, mem_addr_o, inst_o} !== {1'b1, 32'h200, 32'h0}) begin
            fails++;
            $display("FAIL flush_target: req=%0b addr=%h inst=%h want 1/200/0",
                     mem_req_o, mem_addr_o, inst_o);
        end
        tick();
        tick();
        tests++;
        if ({inst_o, pc_o} !== {mw(32'h200), 32'h200}) begin
            fails++;
            $display("FAIL word200: inst=%h pc=%h want %h/200",
                     inst_o, pc_o, mw(32'h200));
        end
    endtask

    task automatic test_stall_pc();
        tick();
        stall_i = 5'b00001;
        tick();
        tests++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h204}) begin
            fails++;
            $display("FAIL pcstall_req: req=%0b addr=%h want 1/204",
                     mem_req_o, mem_addr_o);
        end
        tick();
        tests++;
        if ({inst_o, pc_o} !== {mw(32'h204), 32'h204}) begin
            fails++;
            $display("FAIL pcstall_word: inst=%h pc=%h want %h/204",
                     inst_o, pc_o, mw(32'h204));
        end
        tick();
        tests++;
        if (mem_req_o !== 1'b0) begin
            fails++;
            $display("FAIL pcstall_wait: req=%0b want 0", mem_req_o);
        end
        stall_i = 5'b0;
        tick();
        tests++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h208}) begin
            fails++;
            $display("FAIL pcstall_resume: req=%0b addr=%h want 1/208",
                     mem_req_o, mem_addr_o);
        end
        tick();
        tick();
    endtask

    task automatic test_rdy();
        rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if ({mem_req_o, inst_o, pc_o} !== {1'b0, mw(32'h208), 32'h208}) begin
                fails++;
                $display("FAIL rdy_freeze%0d: req=%0b inst=%h pc=%h want 0/%h/208",
                         i, mem_req_o, inst_o, pc_o, mw(32'h208));
            end
        end
        rdy = 1'b1;
        tick();
        tests++;
        if ({mem_req_o, mem_addr_o, inst_o} !== {1'b1, 32'h20C, 32'h0}) begin
            fails++;
            $display("FAIL rdy_resume: req=%0b addr=%h inst=%h want 1/20c/0",
                     mem_req_o, mem_addr_o, inst_o);
        end
        tick();
        tick();
        tests++;
        if ({inst_o, pc_o} !== {mw(32'h20C), 32'h20C}) begin
            fails++;
            $display("FAIL word20c: inst=%h pc=%h want %h/20c",
                     inst_o, pc_o, mw(32'h20C));
        end
    endtask

    task automatic test_rst_mid();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({mem_req_o, mem_addr_o, inst_o, pc_o} !== 97'h0) begin
            fails++;
            $display("FAIL rst_mid: req=%0b addr=%h inst=%h pc=%h want all 0",
                     mem_req_o, mem_addr_o, inst_o, pc_o);
        end
        tick();
        tests++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0}) begin
            fails++;
            $display("FAIL rst_refetch: req=%0b addr=%h want 1/0",
                     mem_req_o, mem_addr_o);
        end
        tick();
        tick();
        tests++;
        if ({inst_o, pc_o} !== {mw(32'h0), 32'h0}) begin
            fails++;
            $display("FAIL rst_word0: inst=%h pc=%h want %h/0",
                     inst_o, pc_o, mw(32'h0));
        end
    endtask

    task automatic test_ack_branch();
        tick();
        tick();
        br_e_i    = 1'b1;
        br_addr_i = 32'h300;
        tick();
        br_e_i = 1'b0;
        tests++;
        if ({inst_o, mem_req_o} !== {32'h0, 1'b0}) begin
            fails++;
            $display("FAIL ackbr_drop: inst=%h req=%0b want 0/0",
                     inst_o, mem_req_o);
        end
        tick();
        tests++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h300}) begin
            fails++;
            $display("FAIL ackbr_target: req=%0b addr=%h want 1/300",
                     mem_req_o, mem_addr_o);
        end
        tick();
        tick();
        tests++;
        if ({inst_o, pc_o} !== {mw(32'h300), 32'h300}) begin
            fails++;
            $display("FAIL word300: inst=%h pc=%h want %h/300",
                     inst_o, pc_o, mw(32'h300));
        end
    endtask

`ifdef IF_ICACHE_EN
    task automatic test_icache();
        logic [31:0] a;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        tests++;
        if ({inst_o, pc_o} !== {mw(32'hC), 32'hC}) begin
            fails++;
            $display("FAIL ic_pass1: inst=%h pc=%h want %h/c",
                     inst_o, pc_o, mw(32'hC));
        end
        br_e_i    = 1'b1;
        br_addr_i = 32'h0;
        tick();
        br_e_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            a = 32'(i * 4);
            tests++;
            if ({inst_o, pc_o, mem_req_o} !== {mw(a), a, 1'b0}) begin
                fails++;
                $display("FAIL ic_hit%0d: inst=%h pc=%h req=%0b want %h/%h/0",
                         i, inst_o, pc_o, mem_req_o, mw(a), a);
            end
        end
        tick();
        tests++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h10}) begin
            fails++;
            $display("FAIL ic_miss: req=%0b addr=%h want 1/10",
                     mem_req_o, mem_addr_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall_hold();
        test_flush();
        test_stall_pc();
        test_rdy();
        test_rst_mid();
        test_ack_branch();
`ifdef IF_ICACHE_EN
        test_icache();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
